// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter of three register-file write ports with a zero-fill clear sequence
module regfile_write_arbiter #(
  parameter int NREQ = 3
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_clear,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [5*NREQ-1:0] req_reg,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              ctrl_writeEnable,
  output logic [4:0]        ctrl_writeReg,
  output logic [31:0]       data_writeReg,
  output logic              busy
);
  typedef enum logic {RUN, CLEAR} state_t;
  state_t state;
  logic [1:0] rr_ptr, p1, p2, gidx, next_ptr;
  logic [4:0] cnt;
  logic grant;
  logic [4:0] sel_reg;
  logic [31:0] sel_data;
  // Grant the first valid requester at or above rr_ptr; clear, reset and CLEAR state suppress all grants
  always_comb begin
    p1 = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
    p2 = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
    gidx = req_valid[rr_ptr] ? rr_ptr : req_valid[p1] ? p1 : p2;
    grant = (|req_valid) && state == RUN && !ctrl_clear && !ctrl_reset;
    req_ready = grant ? NREQ'(1) << gidx : '0;
    next_ptr = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
    sel_reg = req_reg[5*gidx +: 5];
    sel_data = req_data[32*gidx +: 32];
  end
  // FSM: accept one write per cycle in RUN, or step the zero-fill counter through registers 1..31 in CLEAR
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state <= RUN;
      rr_ptr <= '0;
      cnt <= '0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg <= '0;
      data_writeReg <= '0;
      busy <= 1'b0;
    end else if (state == CLEAR) begin
      ctrl_writeEnable <= 1'b1;
      ctrl_writeReg <= cnt;
      data_writeReg <= '0;
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31) begin
        state <= RUN;
        busy <= 1'b0;
      end
    end else if (ctrl_clear) begin
      state <= CLEAR;
      busy <= 1'b1;
      cnt <= 5'd1;
      ctrl_writeEnable <= 1'b0;
    end else if (grant) begin
      ctrl_writeEnable <= sel_reg != 5'd0;
      ctrl_writeReg <= sel_reg;
      data_writeReg <= sel_data;
      rr_ptr <= next_ptr;
    end else begin
      ctrl_writeEnable <= 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: scoreboard bench for the register-file write arbiter
module tb_regfile_write_arbiter;
  logic clock = 1'b0, ctrl_reset = 1'b0, ctrl_clear = 1'b0;
  logic [2:0] req_valid = '0;
  logic [14:0] req_reg = '0;
  logic [95:0] req_data = '0;
  logic [2:0] req_ready;
  logic ctrl_writeEnable, busy;
  logic [4:0] ctrl_writeReg;
  logic [31:0] data_writeReg;
  typedef struct packed {logic we; logic [4:0] r; logic [31:0] d; logic b;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  bit m_clr;
  int m_rr;
  logic [4:0] m_cnt, m_reg;
  logic [31:0] m_data;

  regfile_write_arbiter #(.NREQ(3)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_clear(ctrl_clear),
    .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data),
    .req_ready(req_ready), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_clr = 0; m_rr = 0; m_cnt = 0; m_reg = 0; m_data = 0;
    q.delete();
  endtask

  task automatic do_reset();
    ctrl_reset = 1'b1;
    req_valid = 3'b111;
    #1;
    check("rst_we", ctrl_writeEnable, 0);
    check("rst_reg", ctrl_writeReg, 0);
    check("rst_data", data_writeReg, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    @(posedge clock); #1;
    check("rst_ready_edge", req_ready, 0);
    check("rst_we_edge", ctrl_writeEnable, 0);
    ctrl_reset = 1'b0;
    req_valid = '0;
    model_reset();
  endtask

  task automatic cyc(input logic [2:0] v, input logic c);
    exp_t e;
    int g;
    logic [2:0] er;
    req_valid = v;
    ctrl_clear = c;
    #3;
    er = '0;
    g = -1;
    if (!m_clr && !c)
      for (int k = 0; k < 3; k++)
        if (g < 0 && v[(m_rr + k) % 3]) g = (m_rr + k) % 3;
    if (g >= 0) er[g] = 1'b1;
    check("ready", req_ready, er);
    if (m_clr) begin
      e.we = 1'b1; e.r = m_cnt; e.d = '0;
      m_reg = m_cnt; m_data = '0;
      if (m_cnt == 5'd31) begin m_clr = 0; m_cnt = 0; end
      else m_cnt = m_cnt + 5'd1;
    end else if (c) begin
      e.we = 1'b0; e.r = m_reg; e.d = m_data;
      m_clr = 1; m_cnt = 5'd1;
    end else if (g >= 0) begin
      m_reg = req_reg[5*g +: 5];
      m_data = req_data[32*g +: 32];
      e.we = m_reg != 5'd0; e.r = m_reg; e.d = m_data;
      m_rr = (g + 1) % 3;
    end else begin
      e.we = 1'b0; e.r = m_reg; e.d = m_data;
    end
    e.b = m_clr;
    q.push_back(e);
    @(posedge clock); #1;
    ctrl_clear = 1'b0;
    if (q.size() == 0) begin
      check("queue_empty", 1, 0);
    end else begin
      e = q.pop_front();
      check("we", ctrl_writeEnable, e.we);
      check("reg", ctrl_writeReg, e.r);
      check("data", data_writeReg, e.d);
      check("busy", busy, e.b);
    end
  endtask

  initial begin
    model_reset();
    do_reset();
    req_reg = {5'd7, 5'd6, 5'd5};
    req_data = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
    for (int i = 0; i < 6; i++) cyc(3'b111, 1'b0);
    cyc(3'b000, 1'b0);
    req_reg = {5'd7, 5'd0, 5'd5};
    req_data = {32'hC0DE_0002, 32'hDEAD_BEEF, 32'hC0DE_0000};
    cyc(3'b010, 1'b0);
    cyc(3'b000, 1'b0);
    req_reg = {5'd9, 5'd8, 5'd3};
    req_data = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
    cyc(3'b001, 1'b1);
    for (int i = 0; i < 33; i++) cyc(3'b001, i == 10);
    cyc(3'b000, 1'b1);
    for (int i = 0; i < 15; i++) cyc(3'b000, 1'b0);
    do_reset();
    cyc(3'b000, 1'b0);
    cyc(3'b111, 1'b0);
    do_reset();
    req_reg = {5'd12, 5'd11, 5'd10};
    req_data = {32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
    for (int i = 0; i < 3; i++) cyc(3'b100, 1'b0);
    cyc(3'b111, 1'b0);
    for (int i = 0; i < 40; i++) begin
      req_reg = 15'($urandom);
      req_data = {$urandom, $urandom, $urandom};
      cyc(3'($urandom), $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < 34; i++) cyc(3'b000, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end
endmodule
